// File: rtl/serv_rf_ram_clr.sv
// Register-file SRAM with a post-reset clear sequencer that zeroes every word before init_done.
// Optional per-word even parity is enabled by defining SERV_RF_RAM_PARITY_EN.
module serv_rf_ram_clr #(
  parameter int unsigned width    = 8,
  parameter int unsigned csr_regs = 4,
  parameter int unsigned raw      = $clog2(32 + csr_regs),
  parameter int unsigned l2w      = $clog2(width),
  parameter int unsigned aw       = 5 + raw - l2w,
  parameter int unsigned depth    = 2**aw
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_init_done,
  output logic             o_parity_err
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [aw-1:0] last_addr = aw'(depth - 1);

  state_e          state_q, state_d;
  logic [aw-1:0]   ccnt_q, ccnt_d;
  logic            init_done_q;
  logic [width-1:0] rdata_q;

  logic            mem_we_c;
  logic [aw-1:0]   mem_addr_c;
  logic [width-1:0] mem_din_c;

  logic [width-1:0] mem [depth];

  // State and clear-counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_CLEAR;
      ccnt_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ccnt_q      <= ccnt_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // Next state and write-port steering; the clear write overrides external writes
  always_comb begin
    state_d    = state_q;
    ccnt_d     = ccnt_q;
    mem_we_c   = 1'b0;
    mem_addr_c = i_waddr;
    mem_din_c  = i_wdata;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c   = 1'b1;
        mem_addr_c = ccnt_q;
        mem_din_c  = '0;
        ccnt_d     = ccnt_q + aw'(1);
        if (ccnt_q == last_addr) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we_c = i_wen;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Array write port; writes presented during reset are dropped
  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we_c) begin
      mem[mem_addr_c] <= mem_din_c;
    end
  end

  // Synchronous read, read-before-write, held when not enabled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      rdata_q <= '0;
    end else if (i_ren) begin
      rdata_q <= mem[i_raddr];
    end
  end

`ifdef SERV_RF_RAM_PARITY_EN
  logic mem_par [depth];
  logic par_err_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we_c) begin
      mem_par[mem_addr_c] <= ^mem_din_c;
    end
  end

  // Parity check registered alongside the read data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par_err_q <= 1'b0;
    end else if (state_q == ST_CLEAR) begin
      par_err_q <= 1'b0;
    end else if (i_ren) begin
      par_err_q <= (^mem[i_raddr]) ^ mem_par[i_raddr];
    end
  end

  assign o_parity_err = par_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_rdata     = rdata_q;
  assign o_init_done = init_done_q;

endmodule

// File: tb/tb_serv_rf_ram_clr.sv
// Randomized self-checking bench for serv_rf_ram_clr against an array-based memory model.
module tb_serv_rf_ram_clr;

  localparam int unsigned W     = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [AW-1:0] i_waddr;
  logic [W-1:0]  i_wdata;
  logic          i_wen;
  logic [AW-1:0] i_raddr;
  logic          i_ren;
  logic [W-1:0]  o_rdata;
  logic          o_init_done;
  logic          o_parity_err;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model_mem [DEPTH];
  logic [W-1:0] exp_rdata;

  serv_rf_ram_clr #(.width(8), .csr_regs(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_waddr     (i_waddr),
    .i_wdata     (i_wdata),
    .i_wen       (i_wen),
    .i_raddr     (i_raddr),
    .i_ren       (i_ren),
    .o_rdata     (o_rdata),
    .o_init_done (o_init_done),
    .o_parity_err(o_parity_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_zero;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
    exp_rdata = '0;
  endtask

  // Runs the clear phase with junk traffic (incl. 0xFF to addr 5 at cycle 2); counts cycles to init_done
  task automatic wait_init(output int n, output bit rd_bad);
    n = 0;
    rd_bad = 1'b0;
    while (o_init_done !== 1'b1 && n < 1000) begin
      i_wen   = (n == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      i_waddr = (n == 2) ? AW'(5) : AW'($urandom);
      i_wdata = (n == 2) ? W'(8'hFF) : W'($urandom);
      i_ren   = 1'($urandom_range(0, 1));
      i_raddr = AW'($urandom);
      tick();
      n++;
      if (o_rdata !== '0) rd_bad = 1'b1;
    end
    i_wen = 1'b0;
    i_ren = 1'b0;
    model_zero();
  endtask

  task automatic test_reset;
    int n;
    bit rd_bad;
    i_rst = 1'b1; i_wen = 1'b0; i_ren = 1'b0;
    i_waddr = '0; i_raddr = '0; i_wdata = '0;
    tick(); tick();
    checks++;
    if (o_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=00", o_rdata); end
    checks++;
    if (o_init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b exp=0", o_init_done); end
    checks++;
    if (o_parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", o_parity_err); end
    i_rst = 1'b0;
    wait_init(n, rd_bad);
    checks++;
    if (n !== DEPTH) begin failures++; $display("FAIL init_cycles got=%0d exp=%0d", n, DEPTH); end
    checks++;
    if (rd_bad) begin failures++; $display("FAIL clear_rdata_zero got=nonzero exp=00"); end
  endtask

  task automatic test_clear_all;
    for (int a = 0; a < DEPTH; a++) begin
      i_ren = 1'b1; i_raddr = AW'(a);
      tick();
      checks++;
      if (o_rdata !== model_mem[a] || o_parity_err !== 1'b0) begin
        failures++;
        $display("FAIL clear_read addr=%0d got=%h/%b exp=%h/0", a, o_rdata, o_parity_err, model_mem[a]);
      end
    end
    exp_rdata = model_mem[DEPTH-1];
    i_ren = 1'b0;
  endtask

  task automatic test_basic;
    i_wen = 1'b1; i_waddr = AW'(8'h12); i_wdata = W'(8'hA5);
    tick();
    model_mem[8'h12] = 8'hA5;
    i_wen = 1'b0; i_ren = 1'b1; i_raddr = AW'(8'h12);
    tick();
    checks++;
    if (o_rdata !== 8'hA5) begin failures++; $display("FAIL basic_read12 got=%h exp=a5", o_rdata); end
    i_raddr = AW'(8'h13);
    tick();
    checks++;
    if (o_rdata !== 8'h00) begin failures++; $display("FAIL basic_read13 got=%h exp=00", o_rdata); end
    // Hold: with ren low the output keeps its last value
    i_ren = 1'b0; i_raddr = AW'(8'h12);
    tick(); tick();
    checks++;
    if (o_rdata !== 8'h00) begin failures++; $display("FAIL hold got=%h exp=00", o_rdata); end
    exp_rdata = 8'h00;
  endtask

  task automatic test_back_to_back;
    i_wen = 1'b1; i_waddr = AW'(8'h40); i_wdata = W'(8'h11);
    tick();
    model_mem[8'h40] = 8'h11;
    i_wdata = W'(8'h3C); i_ren = 1'b1; i_raddr = AW'(8'h40);
    tick();
    model_mem[8'h40] = 8'h3C;
    checks++;
    if (o_rdata !== 8'h11) begin failures++; $display("FAIL rbw_old got=%h exp=11", o_rdata); end
    i_wen = 1'b0;
    tick();
    checks++;
    if (o_rdata !== 8'h3C) begin failures++; $display("FAIL rbw_new got=%h exp=3c", o_rdata); end
    i_ren = 1'b0;
    exp_rdata = 8'h3C;
  endtask

  task automatic test_clear_write_ignored;
    i_ren = 1'b1; i_raddr = AW'(5);
    tick();
    checks++;
    if (o_rdata !== 8'h00) begin failures++; $display("FAIL clear_wr_ignored got=%h exp=00", o_rdata); end
    i_ren = 1'b0;
    exp_rdata = 8'h00;
  endtask

  task automatic test_random;
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      i_wen   = 1'($urandom_range(0, 1));
      i_ren   = 1'($urandom_range(0, 2) != 0);
      i_waddr = AW'($urandom_range(0, 15));
      i_raddr = AW'($urandom_range(0, 15));
      i_wdata = W'($urandom);
      if (i_ren) exp_rdata = model_mem[i_raddr];
      if (i_wen) model_mem[i_waddr] = i_wdata;
      tick();
      checks++;
      if (o_rdata !== exp_rdata || o_parity_err !== 1'b0) begin
        failures++;
        errs++;
        if (errs < 10) $display("FAIL random i=%0d got=%h/%b exp=%h/0", i, o_rdata, o_parity_err, exp_rdata);
      end
    end
    i_wen = 1'b0; i_ren = 1'b0;
  endtask

  task automatic test_reset_mid_clear;
    int n;
    bit rd_bad;
    bit early = 1'b0;
    i_rst = 1'b1;
    tick();
    checks++;
    if (o_init_done !== 1'b0 || o_rdata !== '0) begin
      failures++; $display("FAIL run_reset got=%b/%h exp=0/00", o_init_done, o_rdata);
    end
    i_rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (o_init_done !== 1'b0) early = 1'b1;
    end
    i_rst = 1'b1;
    tick();
    checks++;
    if (early || o_init_done !== 1'b0) begin failures++; $display("FAIL mid_clear_init got=1 exp=0"); end
    i_rst = 1'b0;
    wait_init(n, rd_bad);
    checks++;
    if (n !== DEPTH) begin failures++; $display("FAIL restart_cycles got=%0d exp=%0d", n, DEPTH); end
    for (int a = 0; a < 16; a++) begin
      i_ren = 1'b1; i_raddr = AW'(a);
      tick();
      checks++;
      if (o_rdata !== model_mem[a]) begin
        failures++; $display("FAIL reclear_read addr=%0d got=%h exp=%h", a, o_rdata, model_mem[a]);
      end
    end
    i_ren = 1'b0;
  endtask

`ifdef SERV_RF_RAM_PARITY_EN
  task automatic test_parity;
    i_wen = 1'b1; i_waddr = AW'(7); i_wdata = W'(8'h0F);
    tick();
    i_waddr = AW'(8); i_wdata = W'(8'h33);
    tick();
    i_wen = 1'b0;
    dut.mem[7] = dut.mem[7] ^ 8'h01;
    i_ren = 1'b1; i_raddr = AW'(7);
    tick();
    checks++;
    if (o_rdata !== 8'h0E || o_parity_err !== 1'b1) begin
      failures++; $display("FAIL parity_flip got=%h/%b exp=0e/1", o_rdata, o_parity_err);
    end
    i_raddr = AW'(8);
    tick();
    checks++;
    if (o_rdata !== 8'h33 || o_parity_err !== 1'b0) begin
      failures++; $display("FAIL parity_clean got=%h/%b exp=33/0", o_rdata, o_parity_err);
    end
    i_ren = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_clear_all();
    test_clear_write_ignored();
    test_basic();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
`ifdef SERV_RF_RAM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
